bf16_accumulator: RTL and testbench
===================================

Name: bf16_accumulator

Overview:
Downstream consumer of the BF16 multiplier output stream. It sums a group of BF16 products, delimited by first/last markers, into a wide internal accumulator, then emits one rounded BF16 sum per group. It forms the reduction stage of each MAC-array lane. It has no backpressure, matching the producer.

Parameters:
ACC_FRAC_W, 16, internal accumulator fraction bits below the hidden 1 (legal range 8..24)
CNT_W, 8, width of the per-group element counter

Ports:
clk  in  1  clock
rst_n  in  1  reset; asynchronous, active-low
in_valid  in  1  element valid (producer's out_valid)
in_data  in  16  BF16 element (producer's result)
in_first  in  1  element opens a new group; qualified by in_valid
in_last  in  1  element closes the group; qualified by in_valid
out_valid  out  1  one-cycle pulse; group result valid
out_data  out  16  BF16 group sum
out_count  out  CNT_W  number of elements in the emitted group, saturating
group_drop  out  1  one-cycle pulse; an open group was discarded

Behaviour:
- Reset: out_valid=0, out_data=16'h0000, out_count=0, group_drop=0, FSM=IDLE, accumulator cleared. Reset is asynchronous and takes effect mid-group; the partial group is lost and no output is produced for it.
- FSM states are IDLE (no group open) and ACC (group open).
  - IDLE + in_valid: load the element, count=1; go to ACC, or stay IDLE if in_last. in_first is not required in IDLE.
  - ACC + in_valid & !in_first: acc <= acc + element; count++ (saturates at 2^CNT_W-1).
  - ACC + in_valid & in_first: discard the old group, pulse group_drop next cycle, load the element, count=1.
  - Any accepted element with in_last: the next cycle has out_valid=1, out_data = round(final acc including this element), out_count = final count. FSM returns to IDLE.
  - in_first & in_last together gives a single-element group; out_data = in_data, except that a subnormal input is flushed to zero and any NaN becomes 16'h7FC0.
- Throughput: one element per cycle, back-to-back groups allowed. A new group may start in the cycle after the last element. Latency is 1 cycle from the last element to out_valid.
- Elements with exp==0 are treated as zero; they are counted but add nothing.
- Internal format: sign, 10-bit exponent, 1 hidden bit, ACC_FRAC_W fraction bits.
- Add path (single cycle):
  - Align the smaller-magnitude operand right by the exponent difference. Bits shifted out are truncated. A difference > ACC_FRAC_W+1 contributes zero.
  - Add or subtract the magnitudes, then normalize with a leading-zero shift or a 1-bit right shift.
  - Exact cancellation gives +0.
- Special values are sticky for the rest of the group:
  - Any NaN element makes the group NaN.
  - +inf plus -inf makes the group NaN.
  - Otherwise a group containing inf is inf with that sign.
  - Internal exponent > 254 after an add gives inf with the current sign.
  - Internal exponent < 1 gives zero with the sign kept.
- Output rounding: round to nearest even from the ACC_FRAC_W fraction down to 7 bits. A mantissa carry increments the exponent; if the exponent reaches 255 the output is inf.
- Output encodings: NaN = 16'h7FC0; inf = {sign,8'hFF,7'h00}; zero = {sign,15'h0}.
- out_data holds its value between out_valid pulses.

Decomposition:
- Shared package bf16_pkg holds:
  - field widths (BF16_EXP_W=8, BF16_MAN_W=7) and BF16_BIAS=127
  - constants BF16_QNAN=16'h7FC0, BF16_POS_INF=16'h7F80, BF16_NEG_INF=16'hFF80
  - classify function (zero/inf/nan)
  - accumulator state enum {IDLE, ACC}
- One sub-module, bf16_round_pack: combinational normalize/round/special-encode from the internal format to BF16. It is reusable by later reduction stages.

Test Plan:
1. 0x3F80 (first), then 0x4000 (last) on back-to-back cycles -> out_valid one cycle after the last element, out_data=0x4040, out_count=2.
2. Single 0x3F80 with first&last -> out_data=0x3F80, out_count=1; a second group starting the next cycle, 0x4000 then 0x4000 -> 0x4080, count 2.
3. Cancellation and rounding: group 0x3F80 + 0xBF80 -> 0x0000; group 0x4380 (256) + 0x3F80 (1.0) -> tie, RNE gives 0x4380.
4. Specials: 0x7F80 + 0xFF80 -> 0x7FC0; 0x7F7F + 0x7F7F -> 0x7F80; 0x7FC1 then 0x3F80 -> 0x7FC0.
5. Restart: 0x3F80 (first), then 0x4000 (first&last) -> group_drop pulse one cycle after the second element, out_data=0x4000, count 1; exactly one out_valid.
6. Reset mid-group: 0x3F80 (first), then rst_n low for 1 cycle, then 0x4000 (first&last) -> no output for the aborted group; out_data=0x4000, count 1; out_valid=0 during reset.

Source files
------------

// File: rtl/bf16_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bf16_pkg
// Description : Shared BF16 field widths, special encodings, classifier and
//               accumulator state type.
// Revision    : 1.0
// ============================================================================
package bf16_pkg;

  localparam int BF16_EXP_W = 8;
  localparam int BF16_MAN_W = 7;
  localparam int BF16_BIAS  = 127;

  localparam logic [15:0] BF16_QNAN    = 16'h7FC0;
  localparam logic [15:0] BF16_POS_INF = 16'h7F80;
  localparam logic [15:0] BF16_NEG_INF = 16'hFF80;

  typedef enum logic [1:0] {
    CLS_ZERO = 2'd0,
    CLS_NORM = 2'd1,
    CLS_INF  = 2'd2,
    CLS_NAN  = 2'd3
  } bf16_class_e;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    ACC  = 1'b1
  } acc_state_e;

  // Subnormals (exp==0) are classified as zero: they are flushed.
  function automatic bf16_class_e bf16_classify(input logic [15:0] x);
    bf16_class_e c;
    if (x[BF16_MAN_W +: BF16_EXP_W] == '0)
      c = CLS_ZERO;
    else if (x[BF16_MAN_W +: BF16_EXP_W] == '1)
      c = (x[BF16_MAN_W-1:0] == '0) ? CLS_INF : CLS_NAN;
    else
      c = CLS_NORM;
    return c;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bf16_round_pack.sv
`default_nettype none
// ============================================================================
// Module      : bf16_round_pack
// Description : Rounds a normalized internal-format value (hidden bit at the
//               top of i_man) to BF16 with round-to-nearest-even and encodes
//               zero / inf / NaN.
// Revision    : 1.0
// ============================================================================
module bf16_round_pack
  import bf16_pkg::*;
#(
  parameter int ACC_FRAC_W = 16
) (
  input  logic                  i_sign,
  input  logic [9:0]            i_exp,
  input  logic [ACC_FRAC_W:0]   i_man,
  input  logic                  i_zero,
  input  logic                  i_inf,
  input  logic                  i_nan,
  output logic [15:0]           o_data
);

  localparam int LOW_W = ACC_FRAC_W - BF16_MAN_W;

  logic [BF16_MAN_W-1:0] w_top;
  logic [LOW_W-1:0]      w_low;
  logic [LOW_W-1:0]      w_low_sh;
  logic                  w_guard;
  logic                  w_sticky;
  logic                  w_up;
  logic [BF16_MAN_W:0]   w_rman;
  logic [9:0]            w_rexp;
  logic [15:0]           w_inf;

  assign w_top    = i_man[ACC_FRAC_W-1 -: BF16_MAN_W];
  assign w_low    = i_man[LOW_W-1:0];
  // Dropping the guard bit off the top leaves only the sticky bits.
  assign w_low_sh = w_low << 1;
  assign w_guard  = w_low[LOW_W-1];
  assign w_sticky = |w_low_sh;
  assign w_up     = w_guard & (w_sticky | w_top[0]);
  assign w_rman   = {1'b0, w_top} + {{BF16_MAN_W{1'b0}}, w_up};
  assign w_rexp   = i_exp + {9'd0, w_rman[BF16_MAN_W]};
  assign w_inf    = i_sign ? BF16_NEG_INF : BF16_POS_INF;

  always_comb begin
    if (i_nan)
      o_data = BF16_QNAN;
    else if (i_inf)
      o_data = w_inf;
    else if (i_zero || (i_exp == 10'd0) || !i_man[ACC_FRAC_W])
      o_data = {i_sign, 15'h0000};
    else if (w_rexp >= 10'd255)
      o_data = w_inf;
    else
      o_data = {i_sign, w_rexp[7:0], w_rman[BF16_MAN_W-1:0]};
  end

endmodule
`default_nettype wire

// File: rtl/bf16_accumulator.sv
`default_nettype none
// ============================================================================
// Module      : bf16_accumulator
// Description : Sums first/last-delimited groups of BF16 elements in a wide
//               internal format and emits one rounded BF16 result per group.
// Revision    : 1.0
// ============================================================================
module bf16_accumulator
  import bf16_pkg::*;
#(
  parameter int ACC_FRAC_W = 16,
  parameter int CNT_W      = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [15:0]       in_data,
  input  logic              in_first,
  input  logic              in_last,
  output logic              out_valid,
  output logic [15:0]       out_data,
  output logic [CNT_W-1:0]  out_count,
  output logic              group_drop
);

  localparam int MW   = ACC_FRAC_W + 1;
  localparam int LZ_W = $clog2(MW + 1);

  acc_state_e        r_state;
  logic              r_sign;
  logic [9:0]        r_exp;
  logic [MW-1:0]     r_man;
  logic              r_zero;
  logic              r_inf;
  logic              r_nan;
  logic [CNT_W-1:0]  r_count;
  logic              r_out_valid;
  logic [15:0]       r_out_data;
  logic [CNT_W-1:0]  r_out_count;
  logic              r_drop;

  bf16_class_e       w_cls;
  logic              w_load;
  logic [9:0]        w_e_exp;
  logic [MW-1:0]     w_e_man;
  logic              w_swap;
  logic [9:0]        w_big_exp;
  logic [MW-1:0]     w_big_man;
  logic              w_big_sign;
  logic [9:0]        w_sml_exp;
  logic [MW-1:0]     w_sml_man;
  logic [9:0]        w_shift;
  logic [MW-1:0]     w_sml_al;
  logic [MW:0]       w_sum;
  logic [MW-1:0]     w_dif;
  logic [LZ_W-1:0]   w_lz;
  logic [MW-1:0]     w_norm;
  logic [11:0]       w_exp_sub;
  logic [9:0]        w_exp_inc;
  logic              w_n_sign;
  logic [9:0]        w_n_exp;
  logic [MW-1:0]     w_n_man;
  logic              w_n_zero;
  logic              w_n_inf;
  logic              w_n_nan;
  logic [CNT_W-1:0]  w_n_count;
  logic [15:0]       w_round;

  function automatic logic [LZ_W-1:0] lzc(input logic [MW-1:0] v);
    logic [LZ_W-1:0] n;
    logic            hit;
    n   = '0;
    hit = 1'b0;
    for (int i = MW - 1; i >= 0; i--) begin
      if (!hit) begin
        if (v[i]) hit = 1'b1;
        else      n   = n + LZ_W'(1);
      end
    end
    return n;
  endfunction

  assign w_cls   = bf16_classify(in_data);
  assign w_load  = (r_state == IDLE) || in_first;
  assign w_e_exp = {2'b00, in_data[14:7]};
  assign w_e_man = {1'b1, in_data[6:0], {(ACC_FRAC_W-7){1'b0}}};

  // Magnitude ordering decides which operand is aligned down.
  assign w_swap     = {w_e_exp, w_e_man} > {r_exp, r_man};
  assign w_big_exp  = w_swap ? w_e_exp     : r_exp;
  assign w_big_man  = w_swap ? w_e_man     : r_man;
  assign w_big_sign = w_swap ? in_data[15] : r_sign;
  assign w_sml_exp  = w_swap ? r_exp       : w_e_exp;
  assign w_sml_man  = w_swap ? r_man       : w_e_man;
  assign w_shift    = w_big_exp - w_sml_exp;
  assign w_sml_al   = (w_shift > 10'(ACC_FRAC_W + 1)) ? '0 : (w_sml_man >> w_shift);
  assign w_sum      = {1'b0, w_big_man} + {1'b0, w_sml_al};
  assign w_dif      = w_big_man - w_sml_al;
  assign w_lz       = lzc(w_dif);
  assign w_norm     = w_dif << w_lz;
  assign w_exp_sub  = {2'b00, w_big_exp} - {{(12-LZ_W){1'b0}}, w_lz};
  assign w_exp_inc  = w_big_exp + 10'd1;

  assign w_n_count  = w_load ? CNT_W'(1) : ((&r_count) ? r_count : r_count + CNT_W'(1));

  always_comb begin
    w_n_sign = r_sign;
    w_n_exp  = r_exp;
    w_n_man  = r_man;
    w_n_zero = r_zero;
    w_n_inf  = r_inf;
    w_n_nan  = r_nan;
    if (w_load) begin
      w_n_sign = in_data[15];
      w_n_exp  = w_e_exp;
      w_n_man  = w_e_man;
      w_n_zero = (w_cls == CLS_ZERO);
      w_n_inf  = (w_cls == CLS_INF);
      w_n_nan  = (w_cls == CLS_NAN);
    end else if (r_nan || (w_cls == CLS_NAN)) begin
      w_n_nan = 1'b1;
    end else if (w_cls == CLS_INF) begin
      if (r_inf && (r_sign != in_data[15])) begin
        w_n_nan = 1'b1;
      end else begin
        w_n_inf  = 1'b1;
        w_n_sign = in_data[15];
      end
    end else if (!r_inf && (w_cls == CLS_NORM)) begin
      if (r_zero) begin
        w_n_sign = in_data[15];
        w_n_exp  = w_e_exp;
        w_n_man  = w_e_man;
        w_n_zero = 1'b0;
      end else if (r_sign == in_data[15]) begin
        w_n_sign = w_big_sign;
        if (w_sum[MW]) begin
          w_n_man = w_sum[MW:1];
          w_n_exp = w_exp_inc;
        end else begin
          w_n_man = w_sum[MW-1:0];
          w_n_exp = w_big_exp;
        end
        if (w_n_exp > 10'd254) w_n_inf = 1'b1;
      end else if (w_dif == '0) begin
        w_n_zero = 1'b1;
        w_n_sign = 1'b0;
      end else begin
        w_n_sign = w_big_sign;
        if ((w_exp_sub[11:10] != 2'b00) || (w_exp_sub[9:0] == 10'd0)) begin
          w_n_zero = 1'b1;
        end else begin
          w_n_man = w_norm;
          w_n_exp = w_exp_sub[9:0];
        end
      end
    end
  end

  bf16_round_pack #(
    .ACC_FRAC_W (ACC_FRAC_W)
  ) u_round_pack (
    .i_sign (w_n_sign),
    .i_exp  (w_n_exp),
    .i_man  (w_n_man),
    .i_zero (w_n_zero),
    .i_inf  (w_n_inf),
    .i_nan  (w_n_nan),
    .o_data (w_round)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_sign      <= 1'b0;
      r_exp       <= '0;
      r_man       <= '0;
      r_zero      <= 1'b1;
      r_inf       <= 1'b0;
      r_nan       <= 1'b0;
      r_count     <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= 16'h0000;
      r_out_count <= '0;
      r_drop      <= 1'b0;
    end else begin
      r_out_valid <= 1'b0;
      r_drop      <= 1'b0;
      if (in_valid) begin
        r_sign  <= w_n_sign;
        r_exp   <= w_n_exp;
        r_man   <= w_n_man;
        r_zero  <= w_n_zero;
        r_inf   <= w_n_inf;
        r_nan   <= w_n_nan;
        r_count <= w_n_count;
        r_drop  <= (r_state == ACC) && in_first;
        if (in_last) begin
          r_out_valid <= 1'b1;
          r_out_data  <= w_round;
          r_out_count <= w_n_count;
          r_state     <= IDLE;
        end else begin
          r_state     <= ACC;
        end
      end
    end
  end

  assign out_valid  = r_out_valid;
  assign out_data   = r_out_data;
  assign out_count  = r_out_count;
  assign group_drop = r_drop;

endmodule
`default_nettype wire

// File: tb/tb_bf16_accumulator.sv
`default_nettype none
// ============================================================================
// Module      : tb_bf16_accumulator
// Description : Self-checking bench; directed groups plus random groups
//               compared every cycle against an arithmetic reference model.
// Revision    : 1.0
// ============================================================================
module tb_bf16_accumulator;

  localparam int AF   = 16;
  localparam int CW   = 8;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk      = 1'b0;
  logic          rst_n    = 1'b0;
  logic          in_valid = 1'b0;
  logic [15:0]   in_data  = 16'h0000;
  logic          in_first = 1'b0;
  logic          in_last  = 1'b0;
  logic          out_valid;
  logic [15:0]   out_data;
  logic [CW-1:0] out_count;
  logic          group_drop;

  bf16_accumulator #(
    .ACC_FRAC_W (AF),
    .CNT_W      (CW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_first   (in_first),
    .in_last    (in_last),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_count  (out_count),
    .group_drop (group_drop)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Reference value: (-1)^sign * m * 2^(e - 127 - AF), m normalized to [2^AF, 2^(AF+1)).
  typedef struct {
    bit     nan;
    bit     inf;
    bit     zero;
    bit     sign;
    int     e;
    longint m;
  } macc_t;

  function automatic macc_t from_bf(input logic [15:0] x);
    macc_t r;
    r.nan = 0; r.inf = 0; r.zero = 0;
    r.sign = x[15];
    r.e    = int'(x[14:7]);
    r.m    = 0;
    if (x[14:7] == 8'hFF) begin
      if (x[6:0] != 7'h00) r.nan = 1;
      else                 r.inf = 1;
    end else if (x[14:7] == 8'h00) begin
      r.zero = 1;
    end else begin
      r.m = longint'(128 + int'(x[6:0])) << (AF - 7);
    end
    return r;
  endfunction

  function automatic macc_t add(input macc_t a, input macc_t b);
    macc_t  big, sml, r;
    longint sm, tot;
    int     d;
    r = a;
    if (a.nan || b.nan) begin r.nan = 1; return r; end
    if (b.inf) begin
      if (a.inf && (a.sign != b.sign)) begin r.nan = 1; return r; end
      return b;
    end
    if (a.inf || b.zero) return a;
    if (a.zero) return b;
    if ((a.e > b.e) || ((a.e == b.e) && (a.m >= b.m))) begin big = a; sml = b; end
    else begin big = b; sml = a; end
    d   = big.e - sml.e;
    sm  = (d > AF + 1) ? 0 : (sml.m >> d);
    tot = (big.sign ? -big.m : big.m) + (sml.sign ? -sm : sm);
    r   = big;
    if (tot == 0) begin r.zero = 1; r.sign = 0; return r; end
    r.sign = (tot < 0);
    r.m    = r.sign ? -tot : tot;
    while (r.m >= (longint'(1) << (AF + 1))) begin r.m = r.m >> 1; r.e++; end
    while (r.m <  (longint'(1) << AF))       begin r.m = r.m << 1; r.e--; end
    if (r.e > 254)    r.inf  = 1;
    else if (r.e < 1) r.zero = 1;
    return r;
  endfunction

  function automatic logic [15:0] pack(input macc_t a);
    longint q, rem, half;
    int     e;
    if (a.nan)  return 16'h7FC0;
    if (a.inf)  return {a.sign, 8'hFF, 7'h00};
    if (a.zero) return {a.sign, 15'h0000};
    q    = a.m >> (AF - 7);
    rem  = a.m - (q << (AF - 7));
    half = longint'(1) << (AF - 8);
    if ((rem > half) || ((rem == half) && q[0])) q++;
    e = a.e;
    if (q == 256) begin q = 128; e++; end
    if (e >= 255) return {a.sign, 8'hFF, 7'h00};
    return {a.sign, 8'(e), 7'(q)};
  endfunction

  macc_t       m_acc;
  int          m_cnt   = 0;
  bit          m_open  = 0;
  bit          m_valid = 0;
  bit          m_drop  = 0;
  logic [15:0] m_data  = 16'h0000;
  int          m_count = 0;

  task automatic model_reset();
    m_open = 0; m_valid = 0; m_drop = 0; m_data = 16'h0000; m_count = 0; m_cnt = 0;
  endtask

  // Evaluated at the active edge using the inputs presented in that cycle.
  task automatic model_step();
    m_valid = 0;
    m_drop  = 0;
    if (in_valid) begin
      if (!m_open || in_first) begin
        m_drop = m_open;
        m_acc  = from_bf(in_data);
        m_cnt  = 1;
      end else begin
        m_acc = add(m_acc, from_bf(in_data));
        if (m_cnt < CMAX) m_cnt++;
      end
      if (in_last) begin
        m_valid = 1;
        m_data  = pack(m_acc);
        m_count = m_cnt;
        m_open  = 0;
      end else begin
        m_open = 1;
      end
    end
  endtask

  task automatic compare_outputs();
    chk("cyc.valid", 32'(out_valid), 32'(m_valid));
    chk("cyc.drop",  32'(group_drop), 32'(m_drop));
    chk("cyc.data",  32'(out_data), 32'(m_data));
    if (m_valid) chk("cyc.count", 32'(out_count), 32'(m_count));
  endtask

  always @(negedge clk) if (chk_en) compare_outputs();

  task automatic drive(input bit v, input logic [15:0] d, input bit f, input bit l);
    in_valid = v; in_data = d; in_first = f; in_last = l;
    @(posedge clk);
    if (rst_n) model_step();
    else       model_reset();
    @(negedge clk);
    #1;
  endtask

  task automatic expect_out(input string name, input logic [15:0] d, input int cnt);
    chk({name, ".valid"}, 32'(out_valid), 32'd1);
    chk({name, ".data"},  32'(out_data),  32'(d));
    chk({name, ".count"}, 32'(out_count), 32'(cnt));
  endtask

  function automatic logic [15:0] rand_elem();
    logic       s;
    logic [6:0] m;
    int         k;
    s = 1'($urandom);
    m = 7'($urandom);
    k = $urandom_range(0, 49);
    case (k)
      0:       return {s, 8'hFF, 7'h00};
      1:       return {s, 8'hFF, (m | 7'h01)};
      2:       return {s, 8'h00, m};
      3:       return {s, 8'($urandom_range(250, 254)), m};
      4:       return {s, 8'($urandom_range(1, 3)), m};
      default: return {s, 8'($urandom_range(118, 136)), m};
    endcase
  endfunction

  initial begin
    @(negedge clk);
    #1;
    chk_en = 1'b1;
    chk("rst.valid", 32'(out_valid), 32'd0);
    chk("rst.data",  32'(out_data),  32'h0);
    chk("rst.count", 32'(out_count), 32'd0);
    chk("rst.drop",  32'(group_drop), 32'd0);
    rst_n = 1'b1;

    drive(1, 16'h3F80, 1, 0);
    chk("t1.lat", 32'(out_valid), 32'd0);
    drive(1, 16'h4000, 0, 1);
    expect_out("t1", 16'h4040, 2);

    drive(1, 16'h3F80, 1, 1);
    expect_out("t2a", 16'h3F80, 1);
    drive(1, 16'h4000, 1, 0);
    drive(1, 16'h4000, 0, 1);
    expect_out("t2b", 16'h4080, 2);

    drive(1, 16'h3F80, 1, 0);
    drive(1, 16'hBF80, 0, 1);
    expect_out("t3.cancel", 16'h0000, 2);
    drive(1, 16'h4380, 1, 0);
    drive(1, 16'h3F80, 0, 1);
    expect_out("t3.tie", 16'h4380, 2);

    drive(1, 16'h7F80, 1, 0);
    drive(1, 16'hFF80, 0, 1);
    expect_out("t4.infinf", 16'h7FC0, 2);
    drive(1, 16'h7F7F, 1, 0);
    drive(1, 16'h7F7F, 0, 1);
    expect_out("t4.ovf", 16'h7F80, 2);
    drive(1, 16'h7FC1, 1, 0);
    drive(1, 16'h3F80, 0, 1);
    expect_out("t4.nan", 16'h7FC0, 2);

    drive(1, 16'h3F80, 1, 0);
    drive(1, 16'h4000, 1, 1);
    expect_out("t5", 16'h4000, 1);
    chk("t5.drop", 32'(group_drop), 32'd1);
    drive(0, 16'h0000, 0, 0);
    chk("t5.single", 32'(out_valid), 32'd0);
    chk("t5.dropend", 32'(group_drop), 32'd0);

    drive(1, 16'h3F80, 1, 0);
    in_valid = 1'b0;
    rst_n    = 1'b0;
    model_reset();
    #1;
    chk("t6.rst.valid", 32'(out_valid), 32'd0);
    chk("t6.rst.data",  32'(out_data),  32'h0);
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    drive(1, 16'h4000, 1, 1);
    expect_out("t6", 16'h4000, 1);
    drive(0, 16'h0000, 0, 0);
    chk("t6.single", 32'(out_valid), 32'd0);

    drive(1, 16'h4000, 0, 0);
    drive(1, 16'h3F80, 0, 1);
    expect_out("nofirst", 16'h4040, 2);
    drive(1, 16'h8005, 1, 1);
    expect_out("subn", 16'h8000, 1);

    drive(1, 16'h3F80, 1, 0);
    for (int i = 0; i < 298; i++) drive(1, 16'h3F80, 0, 0);
    drive(1, 16'h3F80, 0, 1);
    expect_out("sat", 16'h4396, CMAX);

    for (int g = 0; g < 400; g++) begin
      int len;
      len = $urandom_range(1, 6);
      for (int i = 0; i < len; i++) begin
        if ($urandom_range(0, 7) == 0) drive(0, 16'($urandom), 1'($urandom), 1'($urandom));
        drive(1, rand_elem(),
              (i == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 24) == 0),
              (i == len - 1));
      end
      if ($urandom_range(0, 1) == 0) drive(0, 16'h0000, 0, 0);
    end

    repeat (3) drive(0, 16'h0000, 0, 0);
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
